// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the sequential multiply/divide unit.
// Operation select, ALU control codes and the iteration count live here.
package muldiv_pkg;

  localparam int ITERS = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Unsigned 32-bit multu/divu sequencer driving the shared ALU, one add/sub
// per cycle. Ports: clk, rst (async high), start/op/operand_a/operand_b
// request; alu_a/alu_b/alu_control out to the ALU, alu_result back;
// hi/lo results, busy, done pulse, stall. Optional: MULDIV_EARLY_TERM_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = muldiv_pkg::ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(ITERS);

  state_t         state, state_d;
  logic [CW-1:0]  counter;
  logic           op_q;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH-1:0] s;
  logic           msb;
  logic           carry;
  logic           borrow;
  logic           last;
  logic           div0;
  logic           early;
  logic [2*WIDTH-1:0] prod_sh;

  assign s      = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign msb    = hi[WIDTH-1];
  assign carry  = alu_result < hi;
  assign borrow = alu_result > s;
  assign last   = counter == CW'(ITERS - 1);
  assign div0   = (op_q == OP_DIV) && (b_reg == '0);

  // Remaining multiplier bits are all zero: the rest of the iterations
  // would only shift, so do them all at once.
`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask = {WIDTH{1'b1}} >> counter;
  assign early    = (op_q == OP_MUL) && ((lo & rem_mask) == '0);
`else
  assign early    = 1'b0;
`endif

  assign prod_sh = {hi, lo} >> (7'd32 - {2'b00, counter});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = RUN;
      RUN:  if (div0 || early || last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    busy        = state == RUN;
    done        = state == DONE;
    if (state == RUN) begin
      if (op_q == OP_MUL) begin
        alu_a = hi;
        alu_b = lo[0] ? b_reg : '0;
      end else begin
        alu_a       = s;
        alu_b       = b_reg;
        alu_control = ALU_SUB;
      end
    end
  end

  assign stall = busy | (start & (state == IDLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      op_q    <= OP_MUL;
      b_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            b_reg   <= operand_b;
            hi      <= '0;
            lo      <= operand_a;
            counter <= '0;
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (div0) begin
            hi <= lo;
            lo <= '1;
          end else if (early) begin
            {hi, lo} <= prod_sh;
          end else if (op_q == OP_MUL) begin
            hi <= {carry, alu_result[WIDTH-1:1]};
            lo <= {alu_result[0], lo[WIDTH-1:1]};
          end else if (msb || !borrow) begin
            hi <= alu_result;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= s;
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic model.
// Includes the parent's ALU so the sequencer sees real add/sub results.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] alu_a, alu_b, alu_result, hi, lo;
  logic [2:0]  alu_control;
  logic        busy, done, stall;

  int n_pass = 0;
  int n_total = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  assign alu_result = (alu_control == 3'b001) ? alu_a - alu_b
                                              : alu_a + alu_b;

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int exp_lat(bit o, logic [31:0] x, logic [31:0] y);
    int n;
    n = 0;
    if (o && y == 0) return 1;
    if (o) return 32;
`ifdef MULDIV_EARLY_TERM_EN
    for (int i = 0; i < 32; i++) if (x[i]) n = i + 1;
    return (n + 1 > 32) ? 32 : n + 1;
`else
    return 32 + n;
`endif
  endfunction

  task automatic run_op(string tag, bit o, logic [31:0] x,
                        logic [31:0] y, int poke);
    logic [63:0] p;
    logic [31:0] eh, el;
    int cyc, busy_cyc, lat;
    bit bad_ctrl, got_done;
    if (!o) begin
      p  = 64'(x) * 64'(y);
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 0) begin
      eh = x;
      el = 32'hFFFF_FFFF;
    end else begin
      eh = x % y;
      el = x / y;
    end
    lat = exp_lat(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = x; operand_b = y;
    #1 check({tag, "_stall_req"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0; op = $urandom; operand_a = $urandom; operand_b = $urandom;
    cyc = 0; busy_cyc = 0; bad_ctrl = 0; got_done = 0;
    while (!got_done && cyc < 100) begin
      if (busy) begin
        busy_cyc++;
        if (!o && alu_control != 3'b000) bad_ctrl = 1;
        if (o && y != 0 && alu_control != 3'b001) bad_ctrl = 1;
      end
      if (poke >= 0) begin
        start = (cyc == poke);
        op = ~o;
        operand_a = $urandom;
        operand_b = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      got_done = done;
    end
    check({tag, "_done"}, 64'(got_done), 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_busy"}, 64'(busy_cyc), 64'(lat));
    check({tag, "_ctrl"}, 64'(bad_ctrl), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, {hi, lo}, {eh, el});
    check({tag, "_stall_end"}, 64'(stall), 64'd0);
  endtask

  initial begin
    int ndone;
    bit o;
    logic [31:0] x, y;
    int r;

    repeat (2) @(posedge clk);
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_flags", {61'd0, busy, done, stall}, 64'd0);
    check("rst_alu", {alu_a, alu_b[28:0], alu_control}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul7x3", 1'b0, 32'd7, 32'd3, -1);
    run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("mulx0", 1'b0, 32'd0, 32'd1234, -1);
    run_op("div100_7", 1'b1, 32'd100, 32'd7, -1);
    run_op("divmsb", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, -1);
    run_op("div5_0", 1'b1, 32'd5, 32'd0, -1);
    run_op("ignore", 1'b1, 32'd100, 32'd7, 5);

    @(negedge clk);
    start = 1'b1; op = 1'b0; operand_a = 32'h1234_5678; operand_b = 32'd99;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    run_op("after_rst", 1'b0, 32'd123456, 32'd7891, -1);

    for (int i = 0; i < 40; i++) begin
      o = $urandom;
      x = $urandom;
      y = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0) y = 0;
      if (r == 1) begin
        y = $urandom_range(0, 15);
        x = $urandom_range(0, 255);
      end
      run_op($sformatf("rnd%0d", i), o, x, y, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
